// File: rtl/otn_pkg.sv
// Shared definitions for the OTN link ARQ sender/receiver pair.
package otn_pkg;

   // ARQ sender FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_RELEASE  = 2'd3
   } arq_state_t;

   // ACK/NAK word layout, shared with the receiver's ACK generator
   localparam int ACK_W       = 2;
   localparam int ACK_SEQ_BIT = 0;
   localparam int ACK_OK_BIT  = 1;

   localparam int TIMEOUT_CYC_DFLT = 100000;
   localparam int MAX_RETRY_DFLT   = 7;
   localparam int RTY_W_DFLT       = 3;

   // Counter width able to hold 0 .. n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arq_timer.sv
// Loadable up/down counter with terminal-count expiry. Up mode counts from the
// cleared/loaded value to tc_val, down mode counts to zero. The counter
// saturates at its terminal value and flags expiry for exactly one enabled
// cycle; a clear or load re-arms the flag.
module arq_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   input  logic             up,
   input  logic [CNT_W-1:0] tc_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q;
   logic             fired_q;
   logic             at_tc;

   assign at_tc   = up ? (cnt_q == tc_val) : (cnt_q == '0);
   assign expired = en && at_tc && !fired_q;

   // Count toward the terminal value, hold there, remember that it fired
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q   <= '0;
         fired_q <= 1'b0;
      end else if (clr) begin
         cnt_q   <= '0;
         fired_q <= 1'b0;
      end else if (load) begin
         cnt_q   <= load_val;
         fired_q <= 1'b0;
      end else if (en) begin
         if (at_tc) begin
            fired_q <= 1'b1;
         end else if (up) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/arq_tx_ctrl.sv
// Stop-and-wait ARQ sequencer for the sender framer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no frame in flight; start as soon as the buffer is ready
//   SEND     | framer serializing the buffered frame
//   WAIT_ACK | waiting for ACK/NAK with matching sequence bit, or timeout
//   RELEASE  | one cycle: buffer may discard frame, sequence bit flips
module arq_tx_ctrl
   import otn_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT,
   parameter int MAX_RETRY   = MAX_RETRY_DFLT,
   parameter int RTY_W       = RTY_W_DFLT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_arq_en,
   input  logic             i_corrupt_en,
   input  logic             i_frm_rdy,
   output logic             o_frm_start,
   output logic             o_seq,
   output logic             o_corrupt,
   input  logic             i_frm_done,
   input  logic             i_ack_vld,
   input  logic             i_ack_seq,
   input  logic             i_ack_ok,
   output logic             o_frm_release,
   output logic             o_fail,
   output logic [RTY_W-1:0] o_retry_cnt,
   output logic             o_busy
);

   localparam int               TMR_W   = cnt_width(TIMEOUT_CYC);
   localparam logic [TMR_W-1:0] TMR_TC  = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

   arq_state_t       state_q, state_d;
   logic             arq_q, arq_d;
   logic             cor_q, cor_d;
   logic             seq_q, seq_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic             start_q, start_d;
   logic             corrupt_q, corrupt_d;
   logic             release_q, release_d;
   logic             fail_q, fail_d;
   logic             busy_q, busy_d;

   logic             ack_match;
   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_exp;

   // ACK/NAK words carrying the other sequence bit are duplicates of an
   // earlier exchange and must not disturb the current wait.
   assign ack_match = i_ack_vld && (i_ack_seq == seq_q);

   // Timer restarts on every entry to WAIT_ACK and only runs while there.
   assign tmr_clr = (state_q == ST_SEND) && i_frm_done && arq_q;
   assign tmr_en  = (state_q == ST_WAIT_ACK);

   arq_timer #(
      .CNT_W (TMR_W)
   ) u_timer (
      .clk_sys  (i_clk),
      .rst_b    (i_rst),
      .clr      (tmr_clr),
      .load     (1'b0),
      .load_val ({TMR_W{1'b0}}),
      .en       (tmr_en),
      .up       (1'b1),
      .tc_val   (TMR_TC),
      .expired  (tmr_exp)
   );

   // Next state and next values of every registered output
   always_comb begin
      state_d = state_q;
      arq_d   = arq_q;
      cor_d   = cor_q;
      seq_d   = seq_q;
      retry_d = retry_q;
      start_d = 1'b0;
      fail_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_frm_rdy) begin
               state_d = ST_SEND;
               start_d = 1'b1;
               arq_d   = i_arq_en;
               cor_d   = i_corrupt_en;
               retry_d = '0;
            end
         end
         ST_SEND: begin
            if (i_frm_done) begin
               state_d = arq_q ? ST_WAIT_ACK : ST_RELEASE;
            end
         end
         ST_WAIT_ACK: begin
            // ACK beats a coincident timeout; NAK plus timeout is one retry
            if (ack_match && i_ack_ok) begin
               state_d = ST_RELEASE;
            end else if ((ack_match && !i_ack_ok) || tmr_exp) begin
               if (retry_q < RTY_MAX) begin
                  retry_d = retry_q + RTY_W'(1);
                  start_d = 1'b1;
                  state_d = ST_SEND;
               end else begin
                  fail_d  = 1'b1;
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            // Flip after drops too, so the receiver sees the next frame as new
            seq_d   = ~seq_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Only the first attempt of a frame is ever corrupted
      corrupt_d = (state_d == ST_SEND) && cor_d && (retry_d == '0);
      release_d = (state_d == ST_RELEASE);
      busy_d    = (state_d != ST_IDLE);
   end

   // State, latched per-frame enables and all outputs are registered
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= ST_IDLE;
         arq_q     <= 1'b0;
         cor_q     <= 1'b0;
         seq_q     <= 1'b0;
         retry_q   <= '0;
         start_q   <= 1'b0;
         corrupt_q <= 1'b0;
         release_q <= 1'b0;
         fail_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         arq_q     <= arq_d;
         cor_q     <= cor_d;
         seq_q     <= seq_d;
         retry_q   <= retry_d;
         start_q   <= start_d;
         corrupt_q <= corrupt_d;
         release_q <= release_d;
         fail_q    <= fail_d;
         busy_q    <= busy_d;
      end
   end

   assign o_frm_start   = start_q;
   assign o_seq         = seq_q;
   assign o_corrupt     = corrupt_q;
   assign o_frm_release = release_q;
   assign o_fail        = fail_q;
   assign o_retry_cnt   = retry_q;
   assign o_busy        = busy_q;

endmodule
